// File: rtl/arbiter_grant_lock_if.sv
// Handshake bundle between the requesting ports, the fixed-priority arbiter
// and the merged output stream. slave = the grant-lock block, master = its environment.
interface arbiter_grant_lock_if #(
    parameter int NUM_PORTS = 8,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_last;
    logic [NUM_PORTS*DATA_W-1:0] req_data;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS-1:0]        arb_requests;
    logic [NUM_PORTS-1:0]        arb_grants;
    logic                        out_valid;
    logic [DATA_W-1:0]           out_data;
    logic                        out_last;
    logic [IDX_W-1:0]            out_idx;
    logic                        out_ready;
    logic                        locked;
    logic                        timeout_err;

    modport master (
        output req_valid, req_last, req_data, arb_grants, out_ready,
        input  req_ready, arb_requests, out_valid, out_data, out_last,
               out_idx, locked, timeout_err
    );

    modport slave (
        input  req_valid, req_last, req_data, arb_grants, out_ready,
        output req_ready, arb_requests, out_valid, out_data, out_last,
               out_idx, locked, timeout_err
    );
endinterface

// File: rtl/arbiter_grant_lock.sv
// Packet-level grant lock behind a combinational fixed-priority arbiter.
// Optional stall timeout is compiled in with `define ARB_GRANT_LOCK_TIMEOUT_EN.

module agl_lane #(
    parameter int DATA_W = 32
) (
    input  logic              sel,
    input  logic              rst_n,
    input  logic              out_ready,
    input  logic              valid,
    input  logic              last,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              valid_m,
    output logic              last_m,
    output logic [DATA_W-1:0] data_m
);
    assign ready   = sel & rst_n & out_ready;
    assign valid_m = sel & valid;
    assign last_m  = sel & last;
    assign data_m  = sel ? data : '0;
endmodule

module arbiter_grant_lock #(
    parameter int NUM_PORTS      = 8,
    parameter int DATA_W         = 32,
    parameter int IDX_W          = $clog2(NUM_PORTS),
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    arbiter_grant_lock_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t                           state;
    logic [IDX_W-1:0]                 idx_q;
    logic                             locked_q;
    logic [NUM_PORTS-1:0]             sel, ready_m, valid_m, last_m;
    logic [NUM_PORTS-1:0][DATA_W-1:0] data_m;
    logic [DATA_W-1:0]                data_sel;
    logic                             valid_sel, last_sel, xfer, tmo;

    // Lowest set bit wins, so a non-one-hot grant still resolves to port 0 first.
    function automatic logic [IDX_W-1:0] lowest(input logic [NUM_PORTS-1:0] v);
        lowest = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (v[i]) lowest = IDX_W'(i);
    endfunction

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
        assign sel[g] = locked_q && (idx_q == IDX_W'(g));
        agl_lane #(.DATA_W(DATA_W)) u_lane (
            .sel       (sel[g]),
            .rst_n     (rst_n),
            .out_ready (bus.out_ready),
            .valid     (bus.req_valid[g]),
            .last      (bus.req_last[g]),
            .data      (bus.req_data[g*DATA_W +: DATA_W]),
            .ready     (ready_m[g]),
            .valid_m   (valid_m[g]),
            .last_m    (last_m[g]),
            .data_m    (data_m[g])
        );
    end

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) data_sel = data_sel | data_m[i];
    end

    assign valid_sel = |valid_m;
    assign last_sel  = |last_m;
    assign xfer      = valid_sel & bus.out_ready;

    assign bus.arb_requests = (rst_n && state == IDLE) ? bus.req_valid : '0;
    assign bus.req_ready    = ready_m;
    assign bus.out_valid    = rst_n & valid_sel;
    assign bus.out_data     = data_sel;
    assign bus.out_last     = last_sel;
    assign bus.out_idx      = idx_q;
    assign bus.locked       = locked_q;

`ifdef ARB_GRANT_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] stall_cnt;
    logic             tmo_q;
    assign tmo = tmo_q;
`else
    // Feature compiled out; the comparison keeps the parameter referenced and is always false.
    assign tmo = (TIMEOUT_CYCLES < 0);
`endif
    assign bus.timeout_err = tmo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx_q    <= '0;
            locked_q <= 1'b0;
`ifdef ARB_GRANT_LOCK_TIMEOUT_EN
            stall_cnt <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.arb_grants) begin
                        state    <= LOCKED;
                        locked_q <= 1'b1;
                        idx_q    <= lowest(bus.arb_grants);
`ifdef ARB_GRANT_LOCK_TIMEOUT_EN
                        stall_cnt <= '0;
                        tmo_q     <= 1'b0;
`endif
                    end
                end
                LOCKED: begin
                    if (tmo || (xfer && last_sel)) begin
                        state    <= IDLE;
                        locked_q <= 1'b0;
`ifdef ARB_GRANT_LOCK_TIMEOUT_EN
                        stall_cnt <= '0;
                        tmo_q     <= 1'b0;
                    end else if (valid_sel) begin
                        stall_cnt <= '0;
                    end else if (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Pulse lands in the cycle where the count equals the limit.
                        stall_cnt <= CNT_W'(TIMEOUT_CYCLES);
                        tmo_q     <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arbiter_grant_lock.sv
// Randomized and directed bench for arbiter_grant_lock against a packet-level reference model;
// the bench also plays the fixed-priority arbiter (optionally returning multi-hot grants).
module tb_arbiter_grant_lock;
    localparam int NP = 8;
    localparam int DW = 32;
    localparam int T  = 16;
`ifdef ARB_GRANT_LOCK_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arbiter_grant_lock_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus();

    arbiter_grant_lock #(.NUM_PORTS(NP), .DATA_W(DW), .TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic multi_hot;
    always_comb begin
        bus.arb_grants = '0;
        if (multi_hot) bus.arb_grants = bus.arb_requests;
        else
            for (int i = NP - 1; i >= 0; i--)
                if (bus.arb_requests[i]) bus.arb_grants = NP'(1) << i;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Source side: one packet per port, beat data = base + beat number.
    bit          pact [NP];
    bit          hold [NP];
    int          plen [NP];
    int          pbeat[NP];
    logic [31:0] pbase[NP];
    bit          rand_gap;
    logic        ordy;

    // Reference model: who owns the output, last locked index, stall run length.
    int owner = -1;
    int midx  = 0;
    int stall = 0;
    int cyc_n = 0;
    int tmo_seen = 0;

    logic [31:0] xd[$];
    int          xp[$];
    int          xc[$];

    function automatic int lowest_of(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int pending();
        int n = 0;
        for (int p = 0; p < NP; p++) if (pact[p]) n++;
        return n;
    endfunction

    task automatic start_pkt(input int p, input int len, input logic [31:0] base);
        pact[p] = 1'b1; plen[p] = len; pbeat[p] = 0; pbase[p] = base;
    endtask

    task automatic clr_obs();
        xd.delete(); xp.delete(); xc.delete();
    endtask

    task automatic cyc();
        logic [NP-1:0] rv, rl, erdy, ereq;
        bit evld, etmo, xf;
        for (int p = 0; p < NP; p++) begin
            rv[p] = pact[p] && !hold[p] && !(rand_gap && $urandom_range(0, 3) == 0);
            rl[p] = pact[p] && (pbeat[p] == plen[p] - 1);
            bus.req_data[p*DW +: DW] = pact[p] ? pbase[p] + 32'(pbeat[p]) : $urandom;
        end
        bus.req_valid = rv;
        bus.req_last  = rl;
        bus.out_ready = ordy;
        @(negedge clk);
        etmo = TMO && owner >= 0 && stall >= T;
        evld = rst_n && owner >= 0 && rv[owner];
        erdy = (rst_n && owner >= 0 && ordy) ? (NP'(1) << owner) : '0;
        ereq = (rst_n && owner < 0) ? rv : '0;
        chk("locked",       64'(bus.locked),       64'(owner >= 0));
        chk("out_idx",      64'(bus.out_idx),      64'(midx));
        chk("out_valid",    64'(bus.out_valid),    64'(evld));
        chk("req_ready",    64'(bus.req_ready),    64'(erdy));
        chk("arb_requests", 64'(bus.arb_requests), 64'(ereq));
        chk("timeout_err",  64'(bus.timeout_err),  64'(etmo));
        chk("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'(1));
        if (owner >= 0) begin
            chk("out_data", 64'(bus.out_data), 64'(bus.req_data[owner*DW +: DW]));
            chk("out_last", 64'(bus.out_last), 64'(rl[owner]));
        end
        xf = evld && ordy;
        if (xf) begin
            xd.push_back(bus.out_data);
            xp.push_back(int'(bus.out_idx));
            xc.push_back(cyc_n);
        end
        if (bus.timeout_err) tmo_seen++;
        @(posedge clk); #1;
        cyc_n++;
        if (xf) begin
            pbeat[owner]++;
            if (pbeat[owner] == plen[owner]) pact[owner] = 1'b0;
        end
        if (!rst_n) begin
            owner = -1; midx = 0; stall = 0;
        end else if (owner < 0) begin
            if (rv != '0) begin owner = lowest_of(rv); midx = owner; stall = 0; end
        end else if (etmo || (xf && rl[owner])) begin
            owner = -1; stall = 0;
        end else if (rv[owner]) stall = 0;
        else stall++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((pending() != 0 || owner >= 0) && n < budget) begin cyc(); n++; end
        chk("drain_left", 64'(pending()), 64'(0));
        for (int p = 0; p < NP; p++) pact[p] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, t0, first;
        logic [NP-1:0] vv;
        rst_n = 1'b0; ordy = 1'b1; multi_hot = 1'b0; rand_gap = 1'b0;
        for (int p = 0; p < NP; p++) begin
            pact[p] = 1'b0; hold[p] = 1'b0; plen[p] = 0; pbeat[p] = 0; pbase[p] = '0;
        end
        bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset with every port requesting.
        for (int p = 0; p < NP; p++) start_pkt(p, 1, 32'h100 * p);
        cyc(); cyc();
        chk("rst_locked", 64'(bus.locked), 64'(0));
        chk("rst_idx",    64'(bus.out_idx), 64'(0));
        for (int p = 0; p < NP; p++) pact[p] = 1'b0;
        rst_n = 1'b1;
        cyc();

        // Single port 5, three beats.
        clr_obs();
        start_pkt(5, 3, 32'hA);
        s = cyc_n;
        cyc();
        chk("p5_lock", 64'(bus.locked), 64'(1));
        chk("p5_idx",  64'(bus.out_idx), 64'(5));
        cyc(); cyc(); cyc();
        chk("p5_idle", 64'(bus.locked), 64'(0));
        chk("p5_n", 64'(xd.size()), 64'(3));
        for (int i = 0; i < xd.size(); i++) begin
            chk("p5_data", 64'(xd[i]), 64'(32'hA + i));
            chk("p5_cyc",  64'(xc[i]), 64'(s + 1 + i));
        end

        // Contention between ports 2 and 6.
        clr_obs();
        start_pkt(2, 2, 32'h200); start_pkt(6, 2, 32'h600);
        drain(30);
        chk("cont_n", 64'(xp.size()), 64'(4));
        for (int i = 0; i < xp.size(); i++) chk("cont_port", 64'(xp[i]), 64'(i < 2 ? 2 : 6));
        chk("cont_gap", 64'(xc[2] - xc[1]), 64'(2));

        // Backpressure mid-packet.
        clr_obs();
        start_pkt(3, 4, 32'h300);
        cyc(); cyc();
        ordy = 1'b0;
        for (int i = 0; i < 4; i++) begin cyc(); chk("bp_lock", 64'(bus.locked), 64'(1)); end
        ordy = 1'b1;
        drain(20);
        chk("bp_n", 64'(xd.size()), 64'(4));
        for (int i = 0; i < xd.size(); i++) chk("bp_data", 64'(xd[i]), 64'(32'h300 + i));

        // Port drops valid after the first beat for 40 cycles.
        clr_obs();
        t0 = tmo_seen;
        start_pkt(1, 3, 32'h110);
        cyc(); cyc();
        hold[1] = 1'b1;
        for (int i = 0; i < 40; i++) cyc();
        chk("stall_lock", 64'(bus.locked), 64'(!TMO));
        hold[1] = 1'b0;
        drain(20);
        chk("stall_n",   64'(xd.size()), 64'(3));
        chk("stall_tmo", 64'(tmo_seen - t0), 64'(TMO));

        // Reset in the middle of a packet.
        clr_obs();
        start_pkt(4, 3, 32'h400);
        cyc(); cyc();
        rst_n = 1'b0;
        cyc();
        chk("rstmid_lock", 64'(bus.locked), 64'(0));
        rst_n = 1'b1;
        drain(20);
        chk("rstmid_n", 64'(xd.size()), 64'(3));

        // Every request pattern with single-beat packets.
        for (int v = 1; v < 256; v++) begin
            vv = NP'(v);
            clr_obs();
            multi_hot = 1'($urandom_range(0, 1));
            for (int p = 0; p < NP; p++) if (vv[p]) start_pkt(p, 1, $urandom);
            drain(40);
            first = lowest_of(vv);
            chk("exh_first", 64'(xp[0]), 64'(first));
            chk("exh_cnt",   64'(xp.size()), 64'($countones(vv)));
        end

        // Random traffic with gaps, backpressure and occasional reset.
        rand_gap = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < NP; p++)
                if (!pact[p] && $urandom_range(0, 5) == 0)
                    start_pkt(p, $urandom_range(1, 4), $urandom);
            ordy      = ($urandom_range(0, 3) != 0);
            multi_hot = 1'($urandom_range(0, 1));
            rst_n     = ($urandom_range(0, 299) != 0);
            cyc();
        end
        rand_gap = 1'b0; ordy = 1'b1; rst_n = 1'b1;
        drain(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/arbiter_grant_lock.md
# arbiter_grant_lock

Packet-level grant holder sitting directly downstream of `fixed_priority_arbiter`. It forwards per-port valid lines to the arbiter, latches the one-hot grant, and holds the lock on the winning port until that port's packet completes (`req_last` beat accepted). It muxes the winner's data onto a single valid/ready output stream. The arbiter itself stays purely combinational; all sequential behaviour (lock, packet tracking, optional timeout) lives here.

## Interface
- `NUM_PORTS`, 8, number of requesting ports (≥2)
- `DATA_W`, 32, payload width per port
- `IDX_W`, `$clog2(NUM_PORTS)`, width of the granted-index output
- `TIMEOUT_CYCLES`, 16, stall limit used only when the timeout feature is compiled in (≥1)

- `clk`  in  1  sole clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req_valid`  in  NUM_PORTS  per-port beat valid
- `req_last`  in  NUM_PORTS  per-port last beat of packet
- `req_data`  in  NUM_PORTS*DATA_W  flattened payloads, port i at `[i*DATA_W +: DATA_W]`
- `req_ready`  out  NUM_PORTS  per-port ready; at most one bit set
- `arb_requests`  out  NUM_PORTS  to arbiter `requests`
- `arb_grants`  in  NUM_PORTS  from arbiter `grants` (one-hot expected)
- `out_valid`  out  1  output beat valid
- `out_data`  out  DATA_W  output payload
- `out_last`  out  1  output last beat
- `out_idx`  out  IDX_W  index of port currently locked
- `out_ready`  in  1  downstream ready
- `locked`  out  1  high while a port holds the lock
- `timeout_err`  out  1  one-cycle pulse on forced release (feature only)

## Operation
- Two states: IDLE, LOCKED. Reset → IDLE.
- IDLE: `arb_requests = req_valid`. If `arb_grants != 0`, latch index of lowest set bit into `out_idx`, go LOCKED at next edge. Non-one-hot grant: lowest index wins (port 0 = highest priority, matching the arbiter).
- LOCKED: `arb_requests = 0`; grants ignored. `out_valid = req_valid[out_idx]`, `out_data`/`out_last` from port `out_idx`, `req_ready[out_idx] = out_ready`, other `req_ready` bits 0.
- Transfer = `out_valid && out_ready`. Transfer with `out_last` → IDLE at next edge. Transfers without last keep lock.
- A port dropping `req_valid` mid-packet does not release the lock (except via timeout).
- `locked` = (state == LOCKED). `out_idx` holds its value in IDLE.
- Reset values: state IDLE, `out_idx` 0, `locked` 0, `out_valid` 0, `req_ready` 0, `timeout_err` 0, stall counter 0. While `rst_n` = 0, `arb_requests` forced to 0.
- Reset mid-packet: lock dropped immediately at that edge; no beat is transferred in the reset cycle (`req_ready`, `out_valid` forced 0 while `rst_n` low).

## Timing
- Request asserted in IDLE at cycle 0 → `locked`=1, `out_valid` in cycle 1 (1-cycle arbitration latency).
- Last beat accepted in cycle k → IDLE in k+1, next winner locked at end of k+1, first beat valid k+2. One bubble cycle between packets; single-beat packets sustain 1 beat / 2 cycles.
- Output is combinational from the locked port's inputs (no output register); `out_ready` → `req_ready` is combinational.

## Configuration
- Macro `ARB_GRANT_LOCK_TIMEOUT_EN`.
- Defined: stall counter (width `$clog2(TIMEOUT_CYCLES+1)`) counts consecutive LOCKED cycles with `req_valid[out_idx]`=0; clears on any cycle with valid high and on entering LOCKED. When it reaches `TIMEOUT_CYCLES`, `timeout_err` pulses for exactly that cycle, state → IDLE at next edge, counter clears.
- Undefined: counter absent, `timeout_err` tied 0, lock held indefinitely until the last beat.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with all `req_valid`=1 → `arb_requests`=0, `out_valid`=0, `locked`=0, `out_idx`=0.
- Single port: port 5 sends 3-beat packet (data 0xA,0xB,0xC, last on third), `out_ready`=1 → `locked` cycle 1, out_data 0xA/0xB/0xC cycles 1–3, `out_idx`=5, IDLE cycle 4.
- Contention: ports 2 and 6 valid with 2-beat packets → port 2 served first; port 6 first beat valid exactly 2 cycles after port 2's last beat; `req_ready[6]`=0 throughout port 2's packet.
- Backpressure: `out_ready`=0 for 4 cycles mid-packet → data held stable, no beat lost, lock retained, `arb_requests`=0.
- Mid-packet stall/reset: port 1 drops valid after beat 1 of 3; without macro lock held 40 cycles and resumes; with `ARB_GRANT_LOCK_TIMEOUT_EN`, `timeout_err` pulses after 16 stall cycles and IDLE follows; separately, `rst_n`=0 mid-packet → IDLE next cycle, `locked`=0.
- Exhaustive: for every `req_valid` value 1..255 with single-beat packets → each lock picks lowest set index and `$countones(req_ready)` ≤ 1 every cycle.
